// File: rtl/slot_pkg.sv
// Shared types and helpers for the 64-slot free-map allocator.
package slot_pkg;

    localparam int NSLOT = 64;
    localparam int IDXW  = 6;

    typedef logic [IDXW-1:0]  slot_idx_t;
    typedef logic [NSLOT-1:0] slot_map_t;
    typedef logic [IDXW:0]    slot_cnt_t;

    function automatic slot_map_t onehot64(slot_idx_t idx);
        onehot64 = slot_map_t'(1) << idx;
    endfunction

endpackage

// File: rtl/slot_free_alloc_if.sv
// Requester/release bus of the slot allocator; stats signals exist only with
// SLOT_ALLOC_STATS_EN defined.
interface slot_free_alloc_if;
    import slot_pkg::*;

    logic      alloc_req;
    logic      alloc_gnt;
    slot_idx_t alloc_idx;
    logic      free_vld;
    slot_idx_t free_idx;
    logic      flush;
    slot_map_t free_map;
    slot_cnt_t free_cnt;
    logic      full;
    logic      dbl_free;
`ifdef SLOT_ALLOC_STATS_EN
    logic [6:0]  hwm_cnt;
    logic [15:0] gnt_stall;
`endif

    modport master (
        output alloc_req, free_vld, free_idx, flush,
        input  alloc_gnt, alloc_idx, free_map, free_cnt, full, dbl_free
`ifdef SLOT_ALLOC_STATS_EN
        , input hwm_cnt, gnt_stall
`endif
    );

    modport slave (
        input  alloc_req, free_vld, free_idx, flush,
        output alloc_gnt, alloc_idx, free_map, free_cnt, full, dbl_free
`ifdef SLOT_ALLOC_STATS_EN
        , output hwm_cnt, gnt_stall
`endif
    );

endinterface

// File: rtl/slot_lowest_pick.sv
// Combinational lowest-set-bit encoder for a 64-bit map: byte ORs, byte pick,
// then in-byte pick.
module slot_lowest_pick
    import slot_pkg::*;
(
    input  slot_map_t map_i,
    output slot_idx_t idx_o,
    output logic      any_o
);

    logic [7:0] byte_any;
    logic [7:0] sel_byte;
    logic [2:0] byte_sel;
    logic [2:0] bit_sel;

    always_comb begin
        byte_any = '0;
        for (int b = 0; b < 8; b++) begin
            byte_any[b] = |map_i[b*8 +: 8];
        end

        // Descending scan so the lowest qualifying entry wins.
        byte_sel = '0;
        for (int b = 7; b >= 0; b--) begin
            if (byte_any[b]) byte_sel = 3'(b);
        end

        sel_byte = map_i[{byte_sel, 3'b000} +: 8];

        bit_sel = '0;
        for (int i = 7; i >= 0; i--) begin
            if (sel_byte[i]) bit_sel = 3'(i);
        end
    end

    assign idx_o = {byte_sel, bit_sel};
    assign any_o = |byte_any;

endmodule

// File: rtl/slot_free_alloc.sv
// 64-entry busy/free bitmap with a registered zero-latency grant candidate.
// Optional occupancy statistics are enabled with SLOT_ALLOC_STATS_EN.
module slot_free_alloc
    import slot_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    slot_free_alloc_if.slave bus
);

    slot_map_t free_map_q, map_d;
    slot_cnt_t free_cnt_q, cnt_d;
    slot_idx_t cand_idx_q, pick_idx;
    logic      cand_vld_q, pick_any;
    logic      dbl_free_q;

    logic      gnt;
    logic      slot_is_free;
    logic      rel_ok;
    logic      dbl_hit;
    slot_map_t gnt_mask;
    slot_map_t rel_mask;

    assign gnt          = bus.alloc_req & cand_vld_q;
    assign slot_is_free = free_map_q[bus.free_idx];
    // The candidate is itself a free slot, so releasing it counts as a double free.
    assign rel_ok       = bus.free_vld & ~slot_is_free & ~bus.flush;
    assign dbl_hit      = bus.free_vld &  slot_is_free & ~bus.flush;

    always_comb begin
        gnt_mask = gnt    ? onehot64(cand_idx_q)   : '0;
        rel_mask = rel_ok ? onehot64(bus.free_idx) : '0;
        if (bus.flush) begin
            map_d = '1;
            cnt_d = slot_cnt_t'(NSLOT);
        end else begin
            map_d = (free_map_q & ~gnt_mask) | rel_mask;
            cnt_d = free_cnt_q - {6'b0, gnt} + {6'b0, rel_ok};
        end
    end

    slot_lowest_pick u_pick (
        .map_i (map_d),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map_q <= '1;
            free_cnt_q <= slot_cnt_t'(NSLOT);
            cand_idx_q <= '0;
            cand_vld_q <= 1'b1;
            dbl_free_q <= 1'b0;
        end else begin
            free_map_q <= map_d;
            free_cnt_q <= cnt_d;
            cand_idx_q <= pick_idx;
            cand_vld_q <= pick_any;
            dbl_free_q <= dbl_free_q | dbl_hit;
        end
    end

    assign bus.alloc_gnt = gnt;
    assign bus.alloc_idx = cand_idx_q;
    assign bus.free_map  = free_map_q;
    assign bus.free_cnt  = free_cnt_q;
    assign bus.full      = (free_cnt_q == '0);
    assign bus.dbl_free  = dbl_free_q;

`ifdef SLOT_ALLOC_STATS_EN
    logic [6:0]  hwm_q;
    logic [6:0]  used_d;
    logic [15:0] stall_q;

    assign used_d = slot_cnt_t'(NSLOT) - cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else begin
            if (bus.flush)           hwm_q <= '0;
            else if (used_d > hwm_q) hwm_q <= used_d;
            if (bus.alloc_req && !cand_vld_q && stall_q != 16'hffff)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.hwm_cnt   = hwm_q;
    assign bus.gnt_stall = stall_q;
`endif

    a_cnt_matches_map: assert property (@(posedge clk) disable iff (!rst_n)
        free_cnt_q == 7'($countones(free_map_q)));

endmodule

// File: tb/tb_slot_free_alloc.sv
// Self-checking bench for slot_free_alloc: directed table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_slot_free_alloc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slot_free_alloc_if bus();

    slot_free_alloc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one bit per slot, 1 = free.
    bit          mfree [64];
    bit          mdbl;
    int          mhwm;
    int          mstall;

    logic        p_req, p_fvld, p_flush;
    logic [5:0]  p_fidx;
    int          p_low;
    bit          p_gnt;

    typedef struct {
        logic       req;
        logic       fvld;
        logic [5:0] fidx;
        logic       gnt;
        logic [5:0] idx;
        logic [6:0] cnt;
        logic       dbl;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_low();
        for (int i = 0; i < 64; i++) if (mfree[i]) return i;
        return -1;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(mfree[i]);
        return c;
    endfunction

    function automatic logic [63:0] m_map();
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = mfree[i];
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) mfree[i] = 1'b1;
        mdbl = 1'b0;
        mhwm = 0;
        mstall = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.alloc_req = 1'b0;
        bus.free_vld  = 1'b0;
        bus.free_idx  = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    // Drive one cycle's inputs in the low phase and compare against the model.
    task automatic pre(input logic req, input logic fvld, input logic [5:0] fidx, input logic fl);
        @(negedge clk);
        bus.alloc_req = req;
        bus.free_vld  = fvld;
        bus.free_idx  = fidx;
        bus.flush     = fl;
        p_req = req; p_fvld = fvld; p_fidx = fidx; p_flush = fl;
        #1;
        p_low = m_low();
        p_gnt = req && (p_low >= 0);
        chk("model_gnt", 64'(bus.alloc_gnt), 64'(p_gnt));
        if (p_gnt) chk("model_idx", 64'(bus.alloc_idx), 64'(p_low));
        chk("model_map", bus.free_map, m_map());
        chk("model_cnt", 64'(bus.free_cnt), 64'(m_cnt()));
        chk("model_full", 64'(bus.full), 64'(m_cnt() == 0));
        chk("model_dbl", 64'(bus.dbl_free), 64'(mdbl));
`ifdef SLOT_ALLOC_STATS_EN
        chk("model_hwm", 64'(bus.hwm_cnt), 64'(mhwm));
        chk("model_stall", 64'(bus.gnt_stall), 64'(mstall));
`endif
    endtask

    task automatic post();
        bit pre_free;
        @(posedge clk);
        if (p_req && p_low < 0 && mstall != 65535) mstall++;
        if (p_flush) begin
            for (int i = 0; i < 64; i++) mfree[i] = 1'b1;
            mhwm = 0;
        end else begin
            pre_free = p_fvld ? mfree[p_fidx] : 1'b0;
            if (p_gnt) mfree[p_low] = 1'b0;
            if (p_fvld) begin
                if (pre_free) mdbl = 1'b1;
                else          mfree[p_fidx] = 1'b1;
            end
            if (64 - m_cnt() > mhwm) mhwm = 64 - m_cnt();
        end
    endtask

    task automatic step(input logic req, input logic fvld, input logic [5:0] fidx, input logic fl);
        pre(req, fvld, fidx, fl);
        post();
    endtask

    initial begin
        //            req fvld fidx gnt idx cnt dbl
        tbl[0]  = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd0, 7'd64, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd1, 7'd63, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd2, 7'd62, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 7'd61, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 6'd20, 1'b0, 6'd0, 7'd61, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 7'd61, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 6'd1,  1'b0, 6'd0, 7'd61, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd1, 7'd62, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 6'd1,  1'b1, 6'd3, 7'd61, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 7'd61, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd1, 7'd61, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 7'd60, 1'b1};

        do_reset();
        #1;
        chk("rst_map", bus.free_map, 64'hffff_ffff_ffff_ffff);
        chk("rst_cnt", 64'(bus.free_cnt), 64'd64);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_dbl", 64'(bus.dbl_free), 64'd0);
        chk("rst_idx", 64'(bus.alloc_idx), 64'd0);

        for (int v = 0; v < 12; v++) begin
            pre(tbl[v].req, tbl[v].fvld, tbl[v].fidx, 1'b0);
            chk($sformatf("tbl%0d_gnt", v), 64'(bus.alloc_gnt), 64'(tbl[v].gnt));
            if (tbl[v].gnt) chk($sformatf("tbl%0d_idx", v), 64'(bus.alloc_idx), 64'(tbl[v].idx));
            chk($sformatf("tbl%0d_cnt", v), 64'(bus.free_cnt), 64'(tbl[v].cnt));
            chk($sformatf("tbl%0d_dbl", v), 64'(bus.dbl_free), 64'(tbl[v].dbl));
            post();
        end

        // Fill completely, then keep requesting while empty.
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        pre(1'b1, 1'b0, 6'd0, 1'b0);
        chk("full_flag", 64'(bus.full), 64'd1);
        chk("full_no_gnt", 64'(bus.alloc_gnt), 64'd0);
        chk("full_cnt", 64'(bus.free_cnt), 64'd0);
        post();
        pre(1'b0, 1'b1, 6'd37, 1'b0);
        chk("full_before_rel", 64'(bus.full), 64'd1);
        post();
        pre(1'b1, 1'b0, 6'd0, 1'b0);
        chk("rel37_full", 64'(bus.full), 64'd0);
        chk("rel37_gnt", 64'(bus.alloc_gnt), 64'd1);
        chk("rel37_idx", 64'(bus.alloc_idx), 64'd37);
        post();
        pre(1'b0, 1'b0, 6'd0, 1'b0);
        chk("rel37_cnt0", 64'(bus.free_cnt), 64'd0);
        post();

        // Busy 0..9, then alloc together with release of slot 4.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        pre(1'b1, 1'b1, 6'd4, 1'b0);
        chk("swap_gnt_idx", 64'(bus.alloc_idx), 64'd10);
        chk("swap_cnt_pre", 64'(bus.free_cnt), 64'd54);
        post();
        pre(1'b1, 1'b0, 6'd0, 1'b0);
        chk("swap_slot4_free", 64'(bus.free_map[4]), 64'd1);
        chk("swap_next_idx", 64'(bus.alloc_idx), 64'd4);
        chk("swap_cnt_same", 64'(bus.free_cnt), 64'd54);
        post();
        // Release of the current candidate in the same cycle it is granted.
        pre(1'b1, 1'b1, 6'd11, 1'b0);
        chk("cand_rel_idx", 64'(bus.alloc_idx), 64'd11);
        post();
        pre(1'b0, 1'b0, 6'd0, 1'b0);
        chk("cand_rel_dbl", 64'(bus.dbl_free), 64'd1);
        chk("cand_rel_busy", 64'(bus.free_map[11]), 64'd0);
        post();

        // 40 busy, flush together with a grant.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
        pre(1'b1, 1'b0, 6'd0, 1'b1);
        chk("flush_gnt", 64'(bus.alloc_gnt), 64'd1);
        post();
        pre(1'b0, 1'b0, 6'd0, 1'b0);
        chk("flush_map", bus.free_map, 64'hffff_ffff_ffff_ffff);
        chk("flush_cnt", 64'(bus.free_cnt), 64'd64);
        chk("flush_idx", 64'(bus.alloc_idx), 64'd0);
`ifdef SLOT_ALLOC_STATS_EN
        chk("flush_hwm", 64'(bus.hwm_cnt), 64'd0);
`endif
        post();

        // Asynchronous reset in the middle of the low phase.
        step(1'b1, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b1, 6'd50, 1'b0);
        @(negedge clk);
        bus.alloc_req = 1'b0;
        bus.free_vld  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_map", bus.free_map, 64'hffff_ffff_ffff_ffff);
        chk("arst_cnt", 64'(bus.free_cnt), 64'd64);
        chk("arst_dbl", 64'(bus.dbl_free), 64'd0);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic rq, fv, fl;
            logic [5:0] fi;
            rq = ($urandom_range(99, 0) < 60);
            fv = ($urandom_range(99, 0) < 30);
            fi = 6'($urandom_range(63, 0));
            fl = ($urandom_range(199, 0) == 0);
            step(rq, fv, fi, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
